// File: rtl/tinyjambu_ctrl_pkg.sv
// Shared types and constants for the masked TinyJAMBU NLFSR round sequencer.
package tinyjambu_ctrl_pkg;

    localparam int unsigned STEPS_A_DEF      = 20;
    localparam int unsigned STEPS_B_DEF      = 32;
    localparam int unsigned ROUNDS_PER_STEP  = 32;
    localparam int unsigned FRESH_PER_GADGET = 3;
    localparam int unsigned FRESH_W_DEF      = ROUNDS_PER_STEP * FRESH_PER_GADGET;

    typedef enum logic [1:0] {
        StIdle,
        StRnd,
        StComp,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/nlfsr_fresh_buf.sv
// Holding register for the fresh randomness fed to the 3-share NLFSR core.
module nlfsr_fresh_buf #(
    parameter int unsigned W = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] buf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= d_i;
        end else if (clr_i) begin
            buf_q <= '0;
        end
    end

    assign q_o = buf_q;

endmodule

// File: rtl/nlfsr_round_ctrl.sv
// Step sequencer for the masked TinyJAMBU NLFSR core (P_a / P_b).
// Define PRNG_STALL_EN to make the RND state wait on rnd_valid_i.
module nlfsr_round_ctrl
    import tinyjambu_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned STEPS_A = STEPS_A_DEF,
    parameter int unsigned STEPS_B = STEPS_B_DEF,
    parameter int unsigned FRESH_W = FRESH_W_DEF,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               perm_sel_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               rnd_valid_i,
    input  logic [FRESH_W-1:0] rnd_i,
    output logic               rnd_ready_o,
    output logic [FRESH_W-1:0] fresh_o,
    output logic               state_upd_o,
    output logic [CNT_W-1:0]   step_o
);

    localparam int unsigned      LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] LAST_A   = CNT_W'(STEPS_A - 1);
    localparam logic [CNT_W-1:0] LAST_B   = CNT_W'(STEPS_B - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             rnd_fire;
    logic             fresh_load;
    logic             fresh_clr;

`ifdef PRNG_STALL_EN
    assign rnd_fire = rnd_valid_i;
`else
    // The PRNG is guaranteed to have data whenever rnd_ready_o is high.
    logic unused_rnd_valid;
    assign unused_rnd_valid = rnd_valid_i;
    assign rnd_fire         = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        step_d      = step_q;
        lat_d       = lat_q;
        busy_o      = (state_q != StIdle);
        done_o      = 1'b0;
        rnd_ready_o = 1'b0;
        state_upd_o = 1'b0;
        fresh_load  = 1'b0;
        fresh_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    last_d  = perm_sel_i ? LAST_B : LAST_A;
                    step_d  = '0;
                    state_d = StRnd;
                end
            end
            StRnd: begin
                rnd_ready_o = 1'b1;
                if (rnd_fire) begin
                    fresh_load = 1'b1;
                    lat_d      = LAT_LOAD;
                    state_d    = StComp;
                end
            end
            StComp: begin
                if (lat_q == '0) begin
                    state_upd_o = 1'b1;
                    if (step_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = StRnd;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StDone: begin
                done_o    = 1'b1;
                fresh_clr = 1'b1;
                if (start_i) begin
                    last_d  = perm_sel_i ? LAST_B : LAST_A;
                    step_d  = '0;
                    state_d = StRnd;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= '0;
            step_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            step_q  <= step_d;
            lat_q   <= lat_d;
        end
    end

    assign step_o = step_q;

    nlfsr_fresh_buf #(
        .W(FRESH_W)
    ) u_fresh_buf (
        .clk   (clk),
        .rst   (rst),
        .load_i(fresh_load),
        .clr_i (fresh_clr),
        .d_i   (rnd_i),
        .q_o   (fresh_o)
    );

endmodule

// File: tb/tb_nlfsr_round_ctrl.sv
// Scoreboard bench for nlfsr_round_ctrl: expected update/done events are queued at start,
// a monitor pops them as the DUT strobes.
module tb_nlfsr_round_ctrl;

    localparam int FW = 96;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          perm_sel_i = 1'b0;
    logic          rnd_valid_i = 1'b1;
    logic [FW-1:0] rnd_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          rnd_ready_o;
    logic [FW-1:0] fresh_o;
    logic          state_upd_o;
    logic [CW-1:0] step_o;

    nlfsr_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .perm_sel_i (perm_sel_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rnd_valid_i(rnd_valid_i),
        .rnd_i      (rnd_i),
        .rnd_ready_o(rnd_ready_o),
        .fresh_o    (fresh_o),
        .state_upd_o(state_upd_o),
        .step_o     (step_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            step;
        logic [FW-1:0] fresh;
    } upd_t;

    upd_t upd_q[$];
    int   done_q[$];
    int   total = 0;
    int   bad = 0;

    int   stall_lo = 0;
    int   stall_hi = 0;
    logic valid_low = 1'b0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [FW-1:0] mk_rnd(input int c);
        logic [31:0] u;
        u = 32'(c);
        return {u, ~u, u ^ 32'hA5A5_A5A5};
    endfunction

    // Expected events for one permutation started in cycle c0; one step may see a PRNG stall.
    task automatic push_perm(input int c0, input bit sel, input int stall_step, input int stall_len);
        int   n;
        int   acc;
        upd_t e;
        n = sel ? 32 : 20;
        for (int k = 0; k < n; k++) begin
            acc     = c0 + 1 + 3 * k + ((k >= stall_step) ? stall_len : 0);
            e.cyc   = acc + 2;
            e.step  = k;
            e.fresh = mk_rnd(acc);
            upd_q.push_back(e);
        end
        done_q.push_back(c0 + 3 * n + 1 + stall_len);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_perm(input bit sel, input int stall_step, input int stall_len);
        start_i    = 1'b1;
        perm_sel_i = sel;
        push_perm(cyc, sel, stall_step, stall_len);
        @(negedge clk);
        start_i    = 1'b0;
        perm_sel_i = 1'b0;
        check("busy_after_start", {95'd0, busy_o}, 96'd1);
        check("ready_in_rnd", {95'd0, rnd_ready_o}, 96'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((upd_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 96'(upd_q.size() + done_q.size()), 96'd0);
        @(negedge clk);
        check("idle_busy", {95'd0, busy_o}, 96'd0);
        check("idle_fresh", fresh_o, 96'd0);
    endtask

    // PRNG model: a fresh word every cycle, valid optionally withheld.
    initial begin
        forever begin
            @(negedge clk);
            rnd_i       = mk_rnd(cyc);
            rnd_valid_i = !(valid_low || (cyc >= stall_lo && cyc < stall_hi));
        end
    end

    logic [FW-1:0] prev_fresh = '0;

    initial begin
        upd_t e;
        int   dc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (state_upd_o) begin
                    if (upd_q.size() == 0) begin
                        check("unexpected_upd", {95'd0, state_upd_o}, 96'd0);
                    end else begin
                        e = upd_q.pop_front();
                        check("upd_cycle", 96'(cyc), 96'(e.cyc));
                        check("upd_step", 96'(step_o), 96'(e.step));
                        check("upd_fresh", fresh_o, e.fresh);
                        check("comp_fresh_held", prev_fresh, e.fresh);
                    end
                end
                if (done_o) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", {95'd0, done_o}, 96'd0);
                    end else begin
                        dc = done_q.pop_front();
                        check("done_cycle", 96'(cyc), 96'(dc));
                    end
                end
            end
            prev_fresh = fresh_o;
        end
    end

    initial begin
        int c0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {95'd0, busy_o}, 96'd0);
        check("rst_done", {95'd0, done_o}, 96'd0);
        check("rst_ready", {95'd0, rnd_ready_o}, 96'd0);
        check("rst_upd", {95'd0, state_upd_o}, 96'd0);
        check("rst_fresh", fresh_o, 96'd0);
        check("rst_step", 96'(step_o), 96'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // P_a, no stall
        start_perm(1'b0, 99, 0);
        drain(200);
        check("pa_last_step", 96'(step_o), 96'd19);

        // P_b, no stall
        start_perm(1'b1, 99, 0);
        drain(300);
        check("pb_last_step", 96'(step_o), 96'd31);

        // Back-to-back with a start pulse during COMP that must be ignored
        c0 = cyc;
        start_perm(1'b0, 99, 0);
        wait_cyc(c0 + 2);
        start_i    = 1'b1;
        perm_sel_i = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        perm_sel_i = 1'b0;
        wait_cyc(c0 + 61);
        check("b2b_done_cycle", {95'd0, done_o}, 96'd1);
        start_i    = 1'b1;
        perm_sel_i = 1'b1;
        push_perm(c0 + 61, 1'b1, 99, 0);
        @(negedge clk);
        start_i    = 1'b0;
        perm_sel_i = 1'b0;
        check("b2b_no_idle_busy", {95'd0, busy_o}, 96'd1);
        check("b2b_no_idle_ready", {95'd0, rnd_ready_o}, 96'd1);
        drain(400);

`ifdef PRNG_STALL_EN
        // PRNG withholds data for the first 4 RND cycles of step 2
        c0       = cyc;
        stall_lo = c0 + 7;
        stall_hi = c0 + 11;
        start_perm(1'b0, 2, 4);
        drain(300);
        stall_lo = 0;
        stall_hi = 0;
`else
        // Valid ignored: timing must match the unstalled P_a run
        valid_low = 1'b1;
        start_perm(1'b0, 99, 0);
        drain(200);
        valid_low = 1'b0;
`endif

        // Reset in the middle of COMP of step 5
        c0 = cyc;
        start_perm(1'b0, 99, 0);
        wait_cyc(c0 + 17);
        rst = 1'b1;
        upd_q.delete();
        done_q.delete();
        #1;
        check("midrst_busy", {95'd0, busy_o}, 96'd0);
        check("midrst_upd", {95'd0, state_upd_o}, 96'd0);
        check("midrst_fresh", fresh_o, 96'd0);
        check("midrst_step", 96'(step_o), 96'd0);
        check("midrst_done", {95'd0, done_o}, 96'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("midrst_stays_idle", {95'd0, busy_o}, 96'd0);

        check("upd_queue_empty", 96'(upd_q.size()), 96'd0);
        check("done_queue_empty", 96'(done_q.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
